// File: rtl/sdmips_pkg.sv
// Shared definitions for the sdmips fetch front end: datapath width,
// default reset vector, fetch-unit states and PC alignment helper.
package sdmips_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;

   // Instructions are word aligned, so the two low address bits never reach pc.
   localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'h0000_0003;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetchState_e;

   function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
      return addr & ~PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/somador_pc.sv
// Sequential PC incrementer: next fetch address is current pc plus a fixed step,
// wrapping modulo 2^XLEN.
module somador_pc
   import sdmips_pkg::*;
#(
   parameter int unsigned STEP = 4
) (
   input  logic [XLEN-1:0] pcCur_i,
   output logic [XLEN-1:0] pcNext_o
);

   assign pcNext_o = pcCur_i + XLEN'(STEP);

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: issues one memory read at a time, holds the returned word
// for decode, and handles redirects. Optional misalign pulse: PC_FETCH_MISALIGN_TRAP_EN.
module pc_fetch
   import sdmips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = PC_RESET_DEFAULT,
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   input  logic            if_ready
`ifdef PC_FETCH_MISALIGN_TRAP_EN
   ,
   output logic            misalign
`endif
);

   fetchState_e     state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] drainAddr_q, drainAddr_d;
   logic [XLEN-1:0] ifPc_q, ifPc_d;
   logic [XLEN-1:0] ifInstr_q, ifInstr_d;
   logic [XLEN-1:0] pcPlusStep;
   logic [XLEN-1:0] redirectTarget;
   logic            transfer;

   somador_pc #(
      .STEP (PC_STEP)
   ) uSomadorPc (
      .pcCur_i  (pc_q),
      .pcNext_o (pcPlusStep)
   );

   assign redirectTarget = alignPc(redirect_pc);
   assign transfer       = if_ready && !stall;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drainAddr_d = drainAddr_q;
      ifPc_d      = ifPc_q;
      ifInstr_d   = ifInstr_q;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (redirect_valid) begin
               pc_d = redirectTarget;
            end
         end

         FETCH: begin
            if (imem_ack) begin
               if (redirect_valid) begin
                  pc_d = redirectTarget;
               end else begin
                  ifInstr_d = imem_rdata;
                  ifPc_d    = pc_q;
                  pc_d      = pcPlusStep;
                  state_d   = HOLD;
               end
            end else if (redirect_valid) begin
               // The bus still owns the old address, so remember it while pc moves on.
               drainAddr_d = pc_q;
               pc_d        = redirectTarget;
               state_d     = DRAIN;
            end
         end

         HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirectTarget;
               state_d = FETCH;
            end else if (transfer) begin
               state_d = FETCH;
            end
         end

         DRAIN: begin
            if (redirect_valid) begin
               pc_d = redirectTarget;
            end
            if (imem_ack) begin
               state_d = FETCH;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         drainAddr_q <= RESET_PC;
         ifPc_q      <= '0;
         ifInstr_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drainAddr_q <= drainAddr_d;
         ifPc_q      <= ifPc_d;
         ifInstr_q   <= ifInstr_d;
      end
   end

   assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
   assign imem_addr = (state_q == DRAIN) ? drainAddr_q : pc_q;
   assign if_valid  = (state_q == HOLD);
   assign if_pc     = ifPc_q;
   assign if_instr  = ifInstr_q;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   // Every state accepts a redirect, so any misaligned target raises the pulse.
   assign misalign_d = redirect_valid && ((redirect_pc & PC_ALIGN_MASK) != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus random traffic checked
// against a request/hold reference model; a second instance covers pc wrap-around.
module tb_pc_fetch;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] STEP    = 32'd4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
   logic        misalign;
   logic        misalign2;
`endif

   logic        rst2_n;
   logic        req2;
   logic [31:0] addr2;
   logic        valid2;
   logic [31:0] pc2;
   logic [31:0] instr2;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model: an outstanding request (with a drop flag) or a held word.
   logic        mIdle;
   logic        mReqActive;
   logic [31:0] mReqAddr;
   logic        mDrop;
   logic        mHeld;
   logic [31:0] mHeldPc;
   logic [31:0] mHeldInstr;
   logic [31:0] mPc;
   logic        mMis;

   always #5 clk = ~clk;

   pc_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_ready       (if_ready)
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      ,
      .misalign       (misalign)
`endif
   );

   pc_fetch #(
      .RESET_PC (32'hFFFF_FFF8),
      .PC_STEP  (4)
   ) dutWrap (
      .clk            (clk),
      .rst_n          (rst2_n),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .stall          (1'b0),
      .imem_req       (req2),
      .imem_addr      (addr2),
      .imem_ack       (1'b1),
      .imem_rdata     (32'h0),
      .if_valid       (valid2),
      .if_pc          (pc2),
      .if_instr       (instr2),
      .if_ready       (1'b1)
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      ,
      .misalign       (misalign2)
`endif
   );

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mIdle      = 1'b1;
      mReqActive = 1'b0;
      mReqAddr   = RST_PC;
      mDrop      = 1'b0;
      mHeld      = 1'b0;
      mHeldPc    = 32'h0;
      mHeldInstr = 32'h0;
      mPc        = RST_PC;
      mMis       = 1'b0;
   endtask

   task automatic startReq();
      mReqActive = 1'b1;
      mReqAddr   = mPc;
   endtask

   task automatic modelStep();
      logic [31:0] tgt;
      tgt = {redirect_pc[31:2], 2'b00};
      if (mIdle) begin
         mIdle = 1'b0;
         if (redirect_valid) mPc = tgt;
         startReq();
      end else if (mHeld) begin
         if (redirect_valid) begin
            mHeld = 1'b0;
            mPc   = tgt;
            startReq();
         end else if (if_ready && !stall) begin
            mHeld = 1'b0;
            startReq();
         end
      end else if (imem_ack) begin
         if (mDrop || redirect_valid) begin
            if (redirect_valid) mPc = tgt;
            mDrop = 1'b0;
            startReq();
         end else begin
            mHeld      = 1'b1;
            mHeldPc    = mReqAddr;
            mHeldInstr = imem_rdata;
            mPc        = mReqAddr + STEP;
            mReqActive = 1'b0;
         end
      end else if (redirect_valid) begin
         mPc   = tgt;
         mDrop = 1'b1;
      end
      mMis = redirect_valid && (redirect_pc[1:0] != 2'b00);
   endtask

   task automatic checkOutput(input string tag);
      cmp({tag, ".req"}, {31'b0, imem_req}, {31'b0, mReqActive});
      if (mReqActive) cmp({tag, ".addr"}, imem_addr, mReqAddr);
      cmp({tag, ".valid"}, {31'b0, if_valid}, {31'b0, mHeld});
      if (mHeld) begin
         cmp({tag, ".ifPc"}, if_pc, mHeldPc);
         cmp({tag, ".ifInstr"}, if_instr, mHeldInstr);
      end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      cmp({tag, ".misalign"}, {31'b0, misalign}, {31'b0, mMis});
`endif
   endtask

   task automatic applyStimulus(input string tag, input logic rv, input logic [31:0] rpc,
                                input logic st, input logic ack, input logic [31:0] rdata,
                                input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      stall          = st;
      imem_ack       = ack;
      imem_rdata     = rdata;
      if_ready       = rdy;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput(tag);
   endtask

   initial begin
      logic [31:0] wrapExp [3];
      logic [31:0] wrapSeen[$];
      logic [31:0] lastWrap;

      rst_n = 1'b0;
      rst2_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      stall = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      if_ready = 1'b0;
      modelReset();

      // Reset values
      @(negedge clk);
      cmp("rst.req", {31'b0, imem_req}, 32'h0);
      cmp("rst.addr", imem_addr, RST_PC);
      cmp("rst.valid", {31'b0, if_valid}, 32'h0);
      cmp("rst.ifPc", if_pc, 32'h0);
      cmp("rst.ifInstr", if_instr, 32'h0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      cmp("rst.misalign", {31'b0, misalign}, 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("idle");

      // Sequential fetch with zero-wait ack, then a three-cycle stall at 0x8
      applyStimulus("seq0", 0, 0, 0, 1, 32'hAAAA_0000, 1);
      cmp("seq0.addrConst", imem_addr, 32'h0);
      applyStimulus("hold0", 0, 0, 0, 1, 32'hAAAA_0000, 1);
      cmp("firstValid", {31'b0, if_valid}, 32'h1);
      cmp("firstIfPc", if_pc, 32'h0);
      applyStimulus("seq4", 0, 0, 0, 1, 32'hAAAA_0004, 1);
      cmp("seq4.addrConst", imem_addr, 32'h4);
      applyStimulus("hold4", 0, 0, 0, 1, 32'hAAAA_0004, 1);
      applyStimulus("seq8", 0, 0, 0, 1, 32'hAAAA_0008, 1);
      cmp("seq8.addrConst", imem_addr, 32'h8);
      applyStimulus("hold8", 0, 0, 0, 1, 32'hAAAA_0008, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("stall", 0, 0, 1, 1, 32'h5555_5555, 1);
         cmp("stall.ifPc", if_pc, 32'h8);
         cmp("stall.ifInstr", if_instr, 32'hAAAA_0008);
         cmp("stall.req", {31'b0, imem_req}, 32'h0);
      end
      applyStimulus("seqC", 0, 0, 0, 1, 32'hAAAA_000C, 1);
      cmp("seqC.addrConst", imem_addr, 32'hC);
      applyStimulus("holdC", 0, 0, 0, 1, 32'hAAAA_000C, 1);
      applyStimulus("seq10", 0, 0, 0, 0, 32'h0, 1);
      cmp("seq10.addrConst", imem_addr, 32'h10);

      // Redirect to 0x100 while the 0x10 request waits three cycles for its ack
      applyStimulus("drain1", 1, 32'h100, 0, 0, 32'h0, 1);
      cmp("drain1.addrConst", imem_addr, 32'h10);
      applyStimulus("drain2", 0, 0, 0, 0, 32'h0, 1);
      cmp("drain2.addrConst", imem_addr, 32'h10);
      applyStimulus("drainAck", 0, 0, 0, 1, 32'hDEAD_0010, 0);
      cmp("redir.addrConst", imem_addr, 32'h100);
      applyStimulus("redirHold", 0, 0, 0, 1, 32'hBBBB_0100, 0);
      cmp("redir.ifPc", if_pc, 32'h100);
      cmp("redir.ifInstr", if_instr, 32'hBBBB_0100);

      // Misaligned redirect target is aligned down
      applyStimulus("misal", 1, 32'h203, 0, 0, 32'h0, 0);
      cmp("misal.addrConst", imem_addr, 32'h200);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      cmp("misal.pulse", {31'b0, misalign}, 32'h1);
`endif
      applyStimulus("misalAfter", 0, 0, 0, 0, 32'h0, 0);
      applyStimulus("misalAck", 0, 0, 0, 1, 32'hCCCC_0200, 0);

      // Asynchronous reset while requesting 0x40
      applyStimulus("req40", 1, 32'h40, 0, 0, 32'h0, 0);
      cmp("req40.addrConst", imem_addr, 32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      cmp("asyncRst.req", {31'b0, imem_req}, 32'h0);
      cmp("asyncRst.valid", {31'b0, if_valid}, 32'h0);
      cmp("asyncRst.addr", imem_addr, RST_PC);
      modelReset();
      imem_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("restartIdle");
      applyStimulus("restart", 0, 0, 0, 1, 32'hEEEE_0000, 1);
      cmp("restart.addrConst", imem_addr, RST_PC);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
         applyStimulus("rand", ($urandom_range(0, 7) == 0), rpc, ($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
      end

      // Wrap-around instance
      wrapExp[0] = 32'hFFFF_FFF8;
      wrapExp[1] = 32'hFFFF_FFFC;
      wrapExp[2] = 32'h0000_0000;
      lastWrap = 32'h0;
      @(negedge clk);
      rst2_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (req2) begin
            wrapSeen.push_back(addr2);
            lastWrap = addr2;
         end
         if (valid2) begin
            cmp("wrap.ifPc", pc2, lastWrap);
            cmp("wrap.ifInstr", instr2, 32'h0);
         end
      end
      cmp("wrap.count", wrapSeen.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         cmp($sformatf("wrap.addr%0d", i),
             (i < wrapSeen.size()) ? wrapSeen[i] : 32'hDEAD_BEEF, wrapExp[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
